// File: rtl/knn_seq_if.sv
// Host-side bundle of the knn job sequencer.
// Groups the start/status, test point, dataset point, result and core signals.
interface knn_seq_if #(
   parameter int DATA_W = 32,
   parameter int NPTS_W = 16,
   parameter int OUT_W  = 16
);
   logic              start;
   logic [NPTS_W-1:0] n_points;
   logic              busy;
   logic              done;
   logic              tp_valid;
   logic [DATA_W-1:0] tp_data;
   logic              tp_ready;
   logic              dp_valid;
   logic [DATA_W-1:0] dp_data;
   logic              dp_ready;
   logic              res_valid;
   logic [OUT_W-1:0]  res_data;
   logic [15:0]       res_solver;
   logic [15:0]       res_rank;
   logic              res_ready;
   logic              knn_clr;
   logic              knn_valid;
   logic              knn_done;
   logic [15:0]       knn_sel;
   logic [15:0]       knn_solver_sel;
   logic [DATA_W-1:0] knn_data_1;
   logic [DATA_W-1:0] knn_data_2;
   logic [OUT_W-1:0]  knn_data_out;

   modport master (
      input  start, n_points, tp_valid, tp_data,
      input  dp_valid, dp_data, res_ready, knn_data_out,
      output busy, done, tp_ready, dp_ready,
      output res_valid, res_data, res_solver, res_rank,
      output knn_clr, knn_valid, knn_done, knn_sel,
      output knn_solver_sel, knn_data_1, knn_data_2
   );

   modport slave (
      output start, n_points, tp_valid, tp_data,
      output dp_valid, dp_data, res_ready, knn_data_out,
      input  busy, done, tp_ready, dp_ready,
      input  res_valid, res_data, res_solver, res_rank,
      input  knn_clr, knn_valid, knn_done, knn_sel,
      input  knn_solver_sel, knn_data_1, knn_data_2
   );
endinterface

// File: rtl/knn_seq.sv
// knn job sequencer: loads one test point per solver, broadcasts the dataset,
// then reads every solver's result registers back as a valid/ready stream.
// Ports: clk, rst (async active-low), bus (knn_seq_if.master: start/status,
// tp/dp input streams, res output stream, knn core host interface).
module knn_seq #(
   parameter int DATA_W    = 32,
   parameter int HW_K      = 10,
   parameter int N_SOLVERS = 10,
   parameter int NPTS_W    = 16,
   parameter int OUT_W     = 16
) (
   input logic clk,
   input logic rst,
   knn_seq_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, CLR, LOAD, STREAM, DRAIN, READ_SET, READ_OUT, FIN
   } state_t;

   localparam logic [15:0] S_LAST = 16'(N_SOLVERS - 1);
   localparam logic [15:0] K_LAST = 16'(HW_K - 1);

   state_t            state;
   logic [15:0]       s;
   logic [15:0]       k;
   logic [NPTS_W-1:0] n_pts;
   logic [NPTS_W-1:0] cnt;
   logic [DATA_W-1:0] tp_d;
   logic [DATA_W-1:0] dp_d;
   logic [OUT_W-1:0]  dout;
   logic              tp_hs;
   logic              dp_hs;

   assign bus.tp_ready = (state == LOAD);
   assign bus.dp_ready = (state == STREAM);
   assign tp_hs = bus.tp_valid & bus.tp_ready;
   assign dp_hs = bus.dp_valid & bus.dp_ready;
   assign tp_d  = bus.tp_data;
   assign dp_d  = bus.dp_data;
   assign dout  = bus.knn_data_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         s                  <= '0;
         k                  <= '0;
         n_pts              <= '0;
         cnt                <= '0;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.res_valid      <= 1'b0;
         bus.res_data       <= '0;
         bus.res_solver     <= '0;
         bus.res_rank       <= '0;
         bus.knn_clr        <= 1'b0;
         bus.knn_valid      <= 1'b0;
         bus.knn_done       <= 1'b0;
         bus.knn_sel        <= '0;
         bus.knn_solver_sel <= '0;
         bus.knn_data_1     <= '0;
         bus.knn_data_2     <= '0;
      end else begin
         bus.knn_valid <= 1'b0;
         bus.knn_clr   <= 1'b0;
         bus.done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  n_pts       <= bus.n_points;
                  cnt         <= '0;
                  s           <= '0;
                  k           <= '0;
                  bus.busy    <= 1'b1;
                  bus.knn_clr <= 1'b1;
                  state       <= CLR;
               end
            end
            CLR: state <= LOAD;
            LOAD: begin
               if (tp_hs) begin
                  bus.knn_valid      <= 1'b1;
                  bus.knn_done       <= 1'b1;
                  bus.knn_solver_sel <= s;
                  bus.knn_data_1     <= tp_d;
                  if (s == S_LAST) begin
                     s     <= '0;
                     state <= (n_pts == '0) ? DRAIN : STREAM;
                  end else begin
                     s <= s + 16'd1;
                  end
               end
            end
            STREAM: begin
               // First STREAM cycle still shows the last load pulse.
               bus.knn_done       <= 1'b0;
               bus.knn_solver_sel <= '0;
               if (dp_hs) begin
                  bus.knn_valid  <= 1'b1;
                  bus.knn_data_2 <= dp_d;
                  cnt            <= cnt + NPTS_W'(1);
                  if (cnt + NPTS_W'(1) == n_pts)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               bus.knn_done       <= 1'b1;
               bus.knn_solver_sel <= s;
               bus.knn_sel        <= k;
               state              <= READ_SET;
            end
            READ_SET: state <= READ_OUT;
            READ_OUT: begin
               // A beat is captured one cycle after SEL changes so
               // the core's combinational DATA_OUT has settled.
               if (!bus.res_valid) begin
                  bus.res_valid  <= 1'b1;
                  bus.res_data   <= dout;
                  bus.res_solver <= s;
                  bus.res_rank   <= k;
               end else if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  if (k == K_LAST) begin
                     k           <= '0;
                     bus.knn_sel <= '0;
                     if (s == S_LAST) begin
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.knn_done <= 1'b0;
                        state        <= FIN;
                     end else begin
                        s                  <= s + 16'd1;
                        bus.knn_solver_sel <= s + 16'd1;
                        state              <= READ_SET;
                     end
                  end else begin
                     k           <= k + 16'd1;
                     bus.knn_sel <= k + 16'd1;
                  end
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_knn_seq.sv
// Directed bench for knn_seq with a small combinational knn core model.
// Table of jobs plus hand-written reset and corner sequences.
module tb_knn_seq;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cyc;

   knn_seq_if #(.DATA_W(32), .NPTS_W(16), .OUT_W(16)) bus ();

   knn_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] core_f(logic [15:0] s, logic [15:0] r);
      return 16'(s * 37 + r * 5 + 256);
   endfunction

   assign bus.knn_data_out = core_f(bus.knn_solver_sel, bus.knn_sel);

   typedef struct {
      int npts;
      int tp_base;
      int gap;
      int stall_at;
      bit restart;
      int exp_pulses;
      int exp_last_d2;
      int exp_beats;
   } job_t;

   typedef struct {
      logic [15:0] d;
      logic [15:0] s;
      logic [15:0] r;
   } beat_t;

   longint loads[$];
   int     d2s[$];
   beat_t  beats[$];
   int     done_cnt;
   int     last_hs;
   int     first_rv;
   bit     stall_prev;
   longint prev_res;
   longint prev_sel;

   task automatic chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Observer: collects core strobes and accepted beats; checks hold under stall.
   initial begin
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_prev = 1'b0;
         end else begin
            if (bus.knn_valid && bus.knn_done)
               loads.push_back({bus.knn_solver_sel, bus.knn_data_1});
            if (bus.knn_valid && !bus.knn_done)
               d2s.push_back(int'(bus.knn_data_2));
            if (bus.res_valid && bus.res_ready)
               beats.push_back('{bus.res_data, bus.res_solver, bus.res_rank});
            if (bus.done)
               done_cnt++;
            if (bus.dp_valid && bus.dp_ready)
               last_hs = cyc + 1;
            if (bus.res_valid && first_rv < 0)
               first_rv = cyc;
            if (stall_prev) begin
               chk("hold_res", {bus.res_valid, bus.res_data,
                                bus.res_solver, bus.res_rank}, prev_res);
               chk("hold_sel", {bus.knn_sel, bus.knn_solver_sel}, prev_sel);
            end
            stall_prev = bus.res_valid && !bus.res_ready;
            prev_res = {bus.res_valid, bus.res_data,
                        bus.res_solver, bus.res_rank};
            prev_sel = {bus.knn_sel, bus.knn_solver_sel};
         end
      end
   end

   task automatic clear_obs();
      loads.delete();
      d2s.delete();
      beats.delete();
      done_cnt = 0;
      last_hs  = -1;
      first_rv = -1;
   endtask

   task automatic drive_tp(int base, bit restart);
      int idx = 0;
      int guard = 0;
      bit hs;
      bit rs_done = 1'b0;
      while (idx < 10 && guard < 500) begin
         bus.tp_valid = 1'b1;
         bus.tp_data  = 32'(base + idx);
         bus.start    = 1'b0;
         if (restart && idx == 3 && !rs_done) begin
            bus.start    = 1'b1;
            bus.n_points = 16'd99;
            rs_done      = 1'b1;
         end
         @(negedge clk);
         hs = bus.tp_ready;
         @(posedge clk);
         #1;
         if (hs) idx++;
         guard++;
      end
      bus.tp_valid = 1'b0;
      bus.start    = 1'b0;
      if (guard >= 500) chk("tp_timeout", idx, 10);
   endtask

   task automatic drive_dp(int npts, int gap);
      int i = 1;
      int acc = 0;
      int guard = 0;
      bit hs;
      while (acc < npts && guard < 2000) begin
         bus.dp_valid = (i % gap == 0);
         bus.dp_data  = 32'(i);
         @(negedge clk);
         hs = bus.dp_valid && bus.dp_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            acc++;
            i++;
         end else if (!bus.dp_valid) begin
            i++;
         end
         guard++;
      end
      bus.dp_valid = 1'b0;
      if (guard >= 2000) chk("dp_timeout", acc, npts);
   endtask

   task automatic sink(int stall_at);
      int guard = 0;
      bus.res_ready = 1'b1;
      if (stall_at >= 0) begin
         while (beats.size() < stall_at && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         bus.res_ready = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         bus.res_ready = 1'b1;
      end
   endtask

   task automatic start_job(int npts);
      bus.start    = 1'b1;
      bus.n_points = 16'(npts);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic run_job(job_t j);
      int guard = 0;
      int nb;
      clear_obs();
      start_job(j.npts);
      fork
         drive_tp(j.tp_base, j.restart);
         drive_dp(j.npts, j.gap);
         sink(j.stall_at);
      join
      while (done_cnt == 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      chk("done_seen", done_cnt, 1);
      chk("busy_at_done", bus.busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("one_done", done_cnt, 1);
      chk("n_loads", loads.size(), 10);
      for (int i = 0; i < loads.size() && i < 10; i++)
         chk("load", loads[i], {16'(i), 32'(j.tp_base + i)});
      chk("n_pulses", d2s.size(), j.exp_pulses);
      for (int i = 0; i < d2s.size(); i++)
         chk("data_2", d2s[i], j.gap * (i + 1));
      if (j.exp_pulses > 0) begin
         chk("last_d2", bus.knn_data_2, j.exp_last_d2);
         chk("latency", first_rv - last_hs, 3);
      end
      nb = beats.size();
      chk("n_beats", nb, j.exp_beats);
      for (int i = 0; i < nb; i++)
         chk("beat", {beats[i].d, beats[i].s, beats[i].r},
             {core_f(16'(i / 10), 16'(i % 10)), 16'(i / 10), 16'(i % 10)});
   endtask

   job_t jobs[5];

   initial begin
      vectors     = 0;
      miscompares = 0;
      jobs[0] = '{6,   5,   1, -1, 1'b0, 6,  6,  100};
      jobs[1] = '{33,  20,  3, -1, 1'b0, 33, 99, 100};
      jobs[2] = '{4,   100, 1, 37, 1'b0, 4,  4,  100};
      jobs[3] = '{5,   7,   2, -1, 1'b1, 5,  10, 100};
      jobs[4] = '{0,   1,   1, -1, 1'b0, 0,  0,  100};

      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.n_points  = '0;
      bus.tp_valid  = 1'b0;
      bus.tp_data   = '0;
      bus.dp_valid  = 1'b0;
      bus.dp_data   = '0;
      bus.res_ready = 1'b1;
      clear_obs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", |{bus.busy, bus.done, bus.tp_ready, bus.dp_ready,
                        bus.res_valid, bus.res_data, bus.res_solver,
                        bus.res_rank, bus.knn_clr, bus.knn_valid,
                        bus.knn_done, bus.knn_sel, bus.knn_solver_sel,
                        bus.knn_data_1, bus.knn_data_2}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Abort in the middle of STREAM.
      start_job(6);
      @(negedge clk);
      chk("clr_pulse", bus.knn_clr, 1);
      drive_tp(50, 1'b0);
      drive_dp(2, 1);
      chk("mid_busy", bus.busy, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_outs", |{bus.busy, bus.done, bus.tp_ready, bus.dp_ready,
                          bus.res_valid, bus.knn_valid, bus.knn_done,
                          bus.knn_solver_sel, bus.knn_data_1,
                          bus.knn_data_2}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);

      for (int i = 0; i < 5; i++) begin
         run_job(jobs[i]);
         repeat (2) @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
